// File: rtl/mac_tile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_tile_pkg
// Description : Shared instruction encoding, dataflow modes and saturation
//               helper for the dual-dataflow MAC tile.
// Revision    : 1.0
// ============================================================================
package mac_tile_pkg;

    localparam int INST_LOAD = 0;
    localparam int INST_EXEC = 1;
    localparam int INST_AUX  = 2;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    // Clamp a wide signed value to the signed range of a narrower word.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] value,
        input int unsigned        width
    );
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end else begin
            return value;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_tile_dual_lanes.sv
`default_nettype none
// ============================================================================
// Module      : mac_lanes
// Description : Combinational LANES-wide dot product plus addend, wrapped or
//               saturated to psum_bw. Activations unsigned, weights signed.
// Revision    : 1.0
// ============================================================================
module mac_lanes
    import mac_tile_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int LANES   = 2,
    parameter int SAT     = 0
) (
    input  logic [bw*LANES-1:0] act,
    input  logic [bw*LANES-1:0] wgt,
    input  logic [psum_bw-1:0]  addend,
    output logic [psum_bw-1:0]  result
);

    localparam int PW    = 2 * bw + 1;
    // Wide enough that no lane sum or addend can overflow before wrap/clamp.
    localparam int FULLW = ((psum_bw > PW) ? psum_bw : PW) + $clog2(LANES + 1) + 1;

    logic signed [FULLW-1:0] total;

    always_comb begin
        total = FULLW'($signed(addend));
        for (int i = 0; i < LANES; i++) begin
            total = total + FULLW'(PW'($signed({1'b0, act[i*bw +: bw]}))
                                 * PW'($signed(wgt[i*bw +: bw])));
        end
    end

    if (SAT != 0) begin : g_sat
        assign result = psum_bw'(sat_signed(64'(total), psum_bw));
    end else begin : g_wrap
        assign result = psum_bw'(total);
    end

endmodule
`default_nettype wire

// File: rtl/mac_tile_dual.sv
`default_nettype none
// ============================================================================
// Module      : mac_tile_dual
// Description : Systolic MAC tile supporting weight-stationary and
//               output-stationary dataflows with kernel reload and drain.
// Revision    : 1.0
// ============================================================================
module mac_tile_dual
    import mac_tile_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int LANES   = 2,
    parameter int SAT     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic [bw*LANES-1:0] in_w,
    output logic [bw*LANES-1:0] out_e,
    input  logic [2:0]          inst_w,
    output logic [2:0]          inst_e,
    input  logic [psum_bw-1:0]  in_n,
    output logic [psum_bw-1:0]  out_s,
    input  logic [bw*LANES-1:0] w_n,
    output logic [bw*LANES-1:0] w_s
);

    logic                mode_q;
    logic [bw*LANES-1:0] a_q;
    logic [bw*LANES-1:0] b_q;
    logic [psum_bw-1:0]  c_q;
    logic                load_ready_q;
    logic [psum_bw-1:0]  acc_q;
    logic                drained_q;
    logic [psum_bw-1:0]  os_out_q;
    logic [bw*LANES-1:0] w_s_q;
    logic [2:0]          inst_e_q;

    logic [psum_bw-1:0]  ws_sum;
    logic [psum_bw-1:0]  os_sum;

    mac_lanes #(
        .bw      (bw),
        .psum_bw (psum_bw),
        .LANES   (LANES),
        .SAT     (SAT)
    ) u_ws_mac (
        .act     (a_q),
        .wgt     (b_q),
        .addend  (c_q),
        .result  (ws_sum)
    );

    mac_lanes #(
        .bw      (bw),
        .psum_bw (psum_bw),
        .LANES   (LANES),
        .SAT     (SAT)
    ) u_os_mac (
        .act     (in_w),
        .wgt     (w_n),
        .addend  (acc_q),
        .result  (os_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= MODE_WS;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            load_ready_q <= 1'b1;
            acc_q        <= '0;
            drained_q    <= 1'b0;
            os_out_q     <= '0;
            w_s_q        <= '0;
            inst_e_q     <= '0;
        end else begin
            // Mode only switches on idle cycles so an operation is never split.
            if (inst_w == 3'b000) begin
                mode_q <= mode;
            end
            inst_e_q[INST_EXEC] <= inst_w[INST_EXEC];
            inst_e_q[INST_AUX]  <= inst_w[INST_AUX];

            if (mode_q == MODE_WS) begin
                c_q       <= in_n;
                drained_q <= 1'b0;
                // Reload beats a simultaneous load; only the first load word sticks.
                if (inst_w[INST_AUX]) begin
                    load_ready_q <= 1'b1;
                end else if (inst_w[INST_LOAD] && load_ready_q) begin
                    b_q          <= in_w;
                    load_ready_q <= 1'b0;
                end
                if (inst_w[INST_EXEC] || inst_w[INST_LOAD]) begin
                    a_q <= in_w;
                end
                if (!load_ready_q) begin
                    inst_e_q[INST_LOAD] <= inst_w[INST_LOAD];
                end
            end else begin
                inst_e_q[INST_LOAD] <= 1'b0;
                if (inst_w[INST_AUX]) begin
                    if (!drained_q) begin
                        os_out_q  <= acc_q;
                        acc_q     <= '0;
                        drained_q <= 1'b1;
                    end else begin
                        os_out_q <= in_n;
                    end
                end else begin
                    drained_q <= 1'b0;
                    if (inst_w[INST_EXEC]) begin
                        acc_q <= os_sum;
                        a_q   <= in_w;
                        w_s_q <= w_n;
                    end
                end
            end
        end
    end

    assign out_s  = (mode_q == MODE_OS) ? os_out_q : ws_sum;
    assign out_e  = a_q;
    assign w_s    = w_s_q;
    assign inst_e = inst_e_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_tile_dual.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_tile_dual
// Description : Scoreboard bench for mac_tile_dual (saturating and wrapping).
// Revision    : 1.0
// ============================================================================
module tb_mac_tile_dual;

    localparam int SIG_OUTS_SAT  = 0;
    localparam int SIG_OUTS_WRAP = 1;
    localparam int SIG_OUTE      = 2;
    localparam int SIG_WS        = 3;
    localparam int SIG_INSTE     = 4;
    localparam int SIG_LDRDY     = 5;
    localparam int SIG_ACC       = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [7:0]  in_w;
    logic [2:0]  inst_w;
    logic [15:0] in_n;
    logic [7:0]  w_n;

    logic [7:0]  out_e_sat, out_e_wrap;
    logic [2:0]  inst_e_sat, inst_e_wrap;
    logic [15:0] out_s_sat, out_s_wrap;
    logic [7:0]  w_s_sat, w_s_wrap;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mac_tile_dual #(.bw(4), .psum_bw(16), .LANES(2), .SAT(1)) dut_sat (
        .clk    (clk),
        .reset  (reset),
        .mode   (mode),
        .in_w   (in_w),
        .out_e  (out_e_sat),
        .inst_w (inst_w),
        .inst_e (inst_e_sat),
        .in_n   (in_n),
        .out_s  (out_s_sat),
        .w_n    (w_n),
        .w_s    (w_s_sat)
    );

    mac_tile_dual #(.bw(4), .psum_bw(16), .LANES(2), .SAT(0)) dut_wrap (
        .clk    (clk),
        .reset  (reset),
        .mode   (mode),
        .in_w   (in_w),
        .out_e  (out_e_wrap),
        .inst_w (inst_w),
        .inst_e (inst_e_wrap),
        .in_n   (in_n),
        .out_s  (out_s_wrap),
        .w_n    (w_n),
        .w_s    (w_s_wrap)
    );

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            SIG_OUTS_SAT:  return 32'(out_s_sat);
            SIG_OUTS_WRAP: return 32'(out_s_wrap);
            SIG_OUTE:      return 32'(out_e_sat);
            SIG_WS:        return 32'(w_s_sat);
            SIG_INSTE:     return 32'(inst_e_sat);
            SIG_LDRDY:     return 32'(dut_sat.load_ready_q);
            SIG_ACC:       return 32'(dut_sat.acc_q);
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Expectation for the state right after the next rising edge.
    task automatic expect_next(input int sig, input logic [31:0] value, input string name);
        sb.push_back('{cyc + 1, sig, value, name});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [2:0] i, input logic [7:0] a,
                         input logic [15:0] n, input logic [7:0] wn);
        inst_w = i;
        in_w   = a;
        in_n   = n;
        w_n    = wn;
    endtask

    task automatic drive_random();
        mode   = 1'($urandom_range(0, 1));
        in_w   = 8'($urandom);
        inst_w = 3'($urandom);
        in_n   = 16'($urandom);
        w_n    = 8'($urandom);
    endtask

    // Monitor: compares every queued expectation on the falling edge it targets.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: check missed at cycle %0d (expected %0h)", e.name, e.cyc, e.exp);
            end else begin
                act = actual(e.sig);
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %0h expected %0h (cycle %0d)", e.name, act, e.exp, cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive_random();
        tick();
        drive_random();
        expect_next(SIG_OUTS_SAT, 32'd0, "rst_out_s");
        expect_next(SIG_OUTE,     32'd0, "rst_out_e");
        expect_next(SIG_WS,       32'd0, "rst_w_s");
        expect_next(SIG_INSTE,    32'd0, "rst_inst_e");
        expect_next(SIG_LDRDY,    32'd1, "rst_load_ready");
        expect_next(SIG_ACC,      32'd0, "rst_acc");
        tick();

        // WS load: kernel {-2, 2}; inst_e[0] held while load_ready was set
        reset = 1'b0;
        mode  = 1'b0;
        drive(3'b001, 8'hE2, 16'd0, 8'h00);
        expect_next(SIG_INSTE, 32'd0,   "ws_load_inst_e");
        expect_next(SIG_LDRDY, 32'd0,   "ws_load_ready_clr");
        expect_next(SIG_OUTE,  32'hE2,  "ws_load_out_e");
        tick();

        // Execute {1,5}, in_n 10: 5*2 + 1*(-2) + 10 = 18
        drive(3'b010, 8'h15, 16'd10, 8'h00);
        expect_next(SIG_OUTS_SAT,  32'd18,    "ws_exec_out_s");
        expect_next(SIG_OUTS_WRAP, 32'd18,    "ws_exec_out_s_wrap");
        expect_next(SIG_INSTE,     32'b010,   "ws_exec_inst_e");
        expect_next(SIG_OUTE,      32'h15,    "ws_exec_out_e");
        tick();

        // Second load word ignored and forwarded east: 4*2 + 3*(-2) = 2
        drive(3'b001, 8'h34, 16'd0, 8'h00);
        expect_next(SIG_INSTE,    32'b001, "ws_fwd_load_inst_e");
        expect_next(SIG_OUTS_SAT, 32'd2,   "ws_kernel_held");
        tick();

        // Reload
        drive(3'b100, 8'h00, 16'd0, 8'h00);
        expect_next(SIG_LDRDY,    32'd1,   "ws_reload_ready");
        expect_next(SIG_INSTE,    32'b100, "ws_reload_inst_e");
        expect_next(SIG_OUTS_SAT, 32'd2,   "ws_reload_out_s");
        tick();

        // New kernel {1,1}
        drive(3'b001, 8'h11, 16'd0, 8'h00);
        expect_next(SIG_INSTE,    32'd0, "ws_reload_load_inst_e");
        expect_next(SIG_LDRDY,    32'd0, "ws_reload_load_ready");
        expect_next(SIG_OUTS_SAT, 32'd2, "ws_reload_load_out_s");
        tick();

        // {2,3} with kernel {1,1}: 5
        drive(3'b010, 8'h23, 16'd0, 8'h00);
        expect_next(SIG_OUTS_SAT, 32'd5, "ws_new_kernel_out_s");
        tick();

        // Load + reload together: reload wins, kernel stays {1,1}: 7+7 = 14
        drive(3'b100, 8'h00, 16'd0, 8'h00);
        tick();
        drive(3'b101, 8'h77, 16'd0, 8'h00);
        expect_next(SIG_OUTS_SAT, 32'd14,  "ws_load_reload_out_s");
        expect_next(SIG_LDRDY,    32'd1,   "ws_load_reload_ready");
        expect_next(SIG_INSTE,    32'b100, "ws_load_reload_inst_e");
        tick();

        // Saturation: kernel {7,7}, act {15,15}, in_n 32760 -> 32970 raw
        drive(3'b001, 8'h77, 16'd0, 8'h00);
        tick();
        drive(3'b010, 8'hFF, 16'd32760, 8'h00);
        expect_next(SIG_OUTS_SAT,  32'd32767, "sat_clamp");
        expect_next(SIG_OUTS_WRAP, 32'h80CA,  "sat_wrap");  // -32566
        tick();

        // Switch to OS on an idle cycle
        mode = 1'b1;
        drive(3'b000, 8'hFF, 16'd0, 8'h00);
        expect_next(SIG_OUTS_SAT, 32'd0, "os_switch_out_s");
        tick();

        // Three executes, dot({1,2},{3,4}) = 2*4 + 1*3 = 11
        for (int k = 1; k <= 3; k++) begin
            drive(3'b010, 8'h12, 16'd0, 8'h34);
            expect_next(SIG_ACC, 32'(11 * k), "os_acc");
            if (k == 1) begin
                expect_next(SIG_WS,    32'h34,  "os_w_s");
                expect_next(SIG_OUTE,  32'h12,  "os_out_e");
                expect_next(SIG_INSTE, 32'b010, "os_inst_e");
            end
            tick();
        end

        // Drain: first cycle emits accumulator, second passes in_n
        drive(3'b100, 8'h00, 16'h1234, 8'h00);
        expect_next(SIG_OUTS_SAT, 32'd33,   "os_drain_first");
        expect_next(SIG_ACC,      32'd0,    "os_drain_acc_clr");
        expect_next(SIG_INSTE,    32'b100,  "os_drain_inst_e");
        tick();
        drive(3'b100, 8'h00, 16'h0BEE, 8'h00);
        expect_next(SIG_OUTS_SAT, 32'h0BEE, "os_drain_pass");
        tick();
        drive(3'b000, 8'h00, 16'h0000, 8'h00);
        expect_next(SIG_OUTS_SAT, 32'h0BEE, "os_drain_hold");
        tick();

        // Collision: dot({2,1},{5,6}) = 16, then drain+execute together
        drive(3'b010, 8'h21, 16'd0, 8'h56);
        expect_next(SIG_ACC, 32'd16, "coll_pre_acc");
        tick();
        drive(3'b110, 8'hFF, 16'd7, 8'hAA);
        expect_next(SIG_OUTS_SAT, 32'd16,   "coll_out_s");
        expect_next(SIG_ACC,      32'd0,    "coll_acc");
        expect_next(SIG_OUTE,     32'h21,   "coll_out_e_hold");
        expect_next(SIG_WS,       32'h56,   "coll_w_s_hold");
        expect_next(SIG_INSTE,    32'b110,  "coll_inst_e");
        tick();
        drive(3'b000, 8'h00, 16'd0, 8'h00);
        tick();

        // Reset in the middle of accumulation
        drive(3'b010, 8'h12, 16'd0, 8'h34);
        expect_next(SIG_ACC, 32'd11, "midrst_pre_acc");
        tick();
        reset = 1'b1;
        expect_next(SIG_ACC,      32'd0, "midrst_acc");
        expect_next(SIG_LDRDY,    32'd1, "midrst_ready");
        expect_next(SIG_OUTS_SAT, 32'd0, "midrst_out_s");
        expect_next(SIG_WS,       32'd0, "midrst_w_s");
        tick();
        reset = 1'b0;
        mode  = 1'b0;
        drive(3'b000, 8'h00, 16'd0, 8'h00);
        tick();
        tick();

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: never compared (expected %0h)", e.name, e.exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
